pc_sequencer: RTL and testbench

Owns the fetch PC register and decides, each cycle, which next-PC source the pipeline uses. Arbitrates redirect requests from ID (JAL), EX (branch, JALR) and the trap path, and generates the 3-bit select that drives the PC source mux. Generates IF/ID flushes, buffers redirects that arrive during a hazard stall, and implements boot hold and halt. Sits between the hazard unit, the EX/ID redirect logic and the IF stage.

---
 rtl/pc_pkg.sv | 36 +++
 rtl/pc_redirect_arb.sv | 64 ++++++
 rtl/pc_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared definitions for the PC sequencer: pc_src mux codes,
//               FSM state encoding and the redirect priority ranking.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // PC source mux select codes
    localparam logic [2:0] PCSRC_SEQ  = 3'd0;
    localparam logic [2:0] PCSRC_BR   = 3'd1;
    localparam logic [2:0] PCSRC_JAL  = 3'd2;
    localparam logic [2:0] PCSRC_JALR = 3'd3;
    localparam logic [2:0] PCSRC_TRAP = 3'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    // Priority rank of a redirect code; higher wins. The mux code order is
    // not the priority order (branch outranks JAL), hence this mapping.
    function automatic logic [2:0] pc_rank(input logic [2:0] code);
        case (code)
            PCSRC_TRAP: pc_rank = 3'd4;
            PCSRC_JALR: pc_rank = 3'd3;
            PCSRC_BR:   pc_rank = 3'd2;
            PCSRC_JAL:  pc_rank = 3'd1;
            default:    pc_rank = 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_redirect_arb.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_arb
// Description : Combinational fixed-priority redirect arbiter. Picks the best
//               live request (trap > JALR > branch > JAL) and lets a pending
//               entry win unless a strictly higher-priority live request
//               exists. Produces the winner code, target and flush pair.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_arb
    import pc_pkg::*;
(
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jal_valid,
    input  logic [31:0] jal_target,
    input  logic [2:0]  pend_code,
    input  logic [31:0] pend_target,
    output logic [2:0]  win_code,
    output logic [31:0] win_target,
    output logic        flush_if,
    output logic        flush_id
);

    logic [2:0]  live_code;
    logic [31:0] live_target;

    // Priority select among live requests, then merge in the pending entry
    always_comb begin
        live_code   = PCSRC_SEQ;
        live_target = 32'h0;
        if (trap_req) begin
            live_code   = PCSRC_TRAP;
            live_target = trap_vec;
        end else if (jalr_valid) begin
            live_code   = PCSRC_JALR;
            live_target = jalr_target;
        end else if (br_taken) begin
            live_code   = PCSRC_BR;
            live_target = br_target;
        end else if (jal_valid) begin
            live_code   = PCSRC_JAL;
            live_target = jal_target;
        end

        win_code   = live_code;
        win_target = live_target;
        // Pending entry is the older instruction, so it keeps ties
        if (pend_code != PCSRC_SEQ && pc_rank(pend_code) >= pc_rank(live_code)) begin
            win_code   = pend_code;
            win_target = pend_target;
        end

        flush_if = (win_code != PCSRC_SEQ);
        flush_id = (win_code == PCSRC_TRAP) || (win_code == PCSRC_JALR) ||
                   (win_code == PCSRC_BR);
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch PC register and next-PC source control. Boot hold,
//               redirect arbitration, stall-time redirect buffering, halt.
//               Optional trap path enabled by defining PC_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target,
    input  logic        jal_valid,
    input  logic [31:0] jal_target,
    input  logic        trap_req,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [2:0]  pc_src,
    output logic        flush_if,
    output logic        flush_id,
    output logic        halted
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    pc_state_t   state, state_next;
    logic [3:0]  boot_cnt, boot_cnt_next;
    logic [2:0]  pend_code, pend_code_next;
    logic [31:0] pend_target, pend_target_next;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;

    logic        trap_live;
    logic [2:0]  run_code, cap_code;
    logic [31:0] run_target, cap_target;
    logic        run_fi, run_fd;
    logic        unused_cap_fi, unused_cap_fd;

`ifdef PC_TRAP_EN
    assign trap_live = trap_req;
`else
    assign trap_live = 1'b0;
    logic unused_trap_req;
    assign unused_trap_req = trap_req;
`endif

    assign pc_plus4 = pc + 32'd4;

    // Un-stalled arbitration: all live requests plus the pending entry
    pc_redirect_arb u_arb_run (
        .trap_req    (trap_live),
        .trap_vec    (TRAP_VEC),
        .jalr_valid  (jalr_valid),
        .jalr_target (jalr_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jal_valid   (jal_valid),
        .jal_target  (jal_target),
        .pend_code   (pend_code),
        .pend_target (pend_target),
        .win_code    (run_code),
        .win_target  (run_target),
        .flush_if    (run_fi),
        .flush_id    (run_fd)
    );

    // Stall capture: JAL excluded (it re-presents from ID); the winner is the
    // new pending entry, which only changes on a strictly higher request
    pc_redirect_arb u_arb_cap (
        .trap_req    (trap_live),
        .trap_vec    (TRAP_VEC),
        .jalr_valid  (jalr_valid),
        .jalr_target (jalr_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jal_valid   (1'b0),
        .jal_target  (jal_target),
        .pend_code   (pend_code),
        .pend_target (pend_target),
        .win_code    (cap_code),
        .win_target  (cap_target),
        .flush_if    (unused_cap_fi),
        .flush_id    (unused_cap_fd)
    );

    // Next-state, next-PC, pending update and Mealy outputs
    always_comb begin
        state_next       = state;
        boot_cnt_next    = boot_cnt;
        pend_code_next   = pend_code;
        pend_target_next = pend_target;
        pc_next          = pc;
        pc_src           = PCSRC_SEQ;
        flush_if         = 1'b0;
        flush_id         = 1'b0;
        if (rst) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else begin
            case (state)
                ST_BOOT: begin
                    flush_if      = 1'b1;
                    flush_id      = 1'b1;
                    boot_cnt_next = boot_cnt + 4'd1;
                    if (boot_cnt == BOOT_LAST) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stall) begin
                        pend_code_next   = cap_code;
                        pend_target_next = cap_target;
                    end else begin
                        pend_code_next = PCSRC_SEQ;
                        if (halt_req && run_code != PCSRC_TRAP) begin
                            state_next = ST_HALT;
                            pc_next    = pc_plus4;
                        end else begin
                            pc_src   = run_code;
                            flush_if = run_fi;
                            flush_id = run_fd;
                            pc_next  = (run_code == PCSRC_SEQ) ? pc_plus4 : run_target;
                        end
                    end
                end
                default: begin
                    // HALT: everything frozen until reset
                end
            endcase
        end
    end

    // State, PC, boot counter, pending entry and halted flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            boot_cnt    <= 4'd0;
            pend_code   <= PCSRC_SEQ;
            pend_target <= 32'h0;
            pc          <= RESET_PC;
            halted      <= 1'b0;
        end else begin
            state       <= state_next;
            boot_cnt    <= boot_cnt_next;
            pend_code   <= pend_code_next;
            pend_target <= pend_target_next;
            pc          <= pc_next;
            halted      <= (state_next == ST_HALT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Scoreboard bench for pc_sequencer. A driver issues directed
//               and random stimulus and pushes the reference model's
//               expectation; a monitor pops and compares every cycle.
//               Trap scenarios are included when PC_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int          BC      = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] TVEC    = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, br_taken, jalr_valid, jal_valid, trap_req, halt_req;
    logic [31:0] br_target, jalr_target, jal_target;
    logic [31:0] pc;
    logic [2:0]  pc_src;
    logic        flush_if, flush_id, halted;

    logic [31:0] pc2;
    logic [2:0]  unused_src2;
    logic        unused_fi2, unused_fd2, unused_h2;

    pc_sequencer #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC), .BOOT_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jalr_valid(jalr_valid), .jalr_target(jalr_target),
        .jal_valid(jal_valid), .jal_target(jal_target),
        .trap_req(trap_req), .halt_req(halt_req),
        .pc(pc), .pc_src(pc_src), .flush_if(flush_if), .flush_id(flush_id),
        .halted(halted)
    );

    // Second instance parked near the top of the address space for the wrap case
    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .TRAP_VEC(TVEC), .BOOT_CYCLES(BC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0),
        .br_taken(1'b0), .br_target(32'h0),
        .jalr_valid(1'b0), .jalr_target(32'h0),
        .jal_valid(1'b0), .jal_target(32'h0),
        .trap_req(1'b0), .halt_req(1'b0),
        .pc(pc2), .pc_src(unused_src2), .flush_if(unused_fi2), .flush_id(unused_fd2),
        .halted(unused_h2)
    );

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic [2:0]  src;
        logic        fi;
        logic        fd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (post-reset at start)
    logic [31:0] m_pc        = RST_PC;
    int          m_boot_left = BC;
    bit          m_halted    = 1'b0;
    int          pend_rank   = 0;
    logic [2:0]  pend_code   = 3'd0;
    logic [31:0] pend_tgt    = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expectation for the current cycle, then advance one edge
    task automatic model_push();
        exp_t        e;
        int          best_rank;
        logic [2:0]  bc;
        logic [31:0] bt;
        bit          tr;
`ifdef PC_TRAP_EN
        tr = trap_req;
`else
        tr = 1'b0;
`endif
        e.pc = m_pc; e.halted = m_halted; e.src = 3'd0; e.fi = 1'b0; e.fd = 1'b0;
        if (rst) begin
            e.fi = 1'b1; e.fd = 1'b1;
            m_pc = RST_PC; m_boot_left = BC; m_halted = 1'b0; pend_rank = 0;
        end else if (m_boot_left > 0) begin
            e.fi = 1'b1; e.fd = 1'b1;
            m_boot_left--;
        end else if (!m_halted) begin
            best_rank = pend_rank; bc = pend_code; bt = pend_tgt;
            if (tr && 4 > best_rank)         begin best_rank = 4; bc = 3'd4; bt = TVEC;        end
            if (jalr_valid && 3 > best_rank) begin best_rank = 3; bc = 3'd3; bt = jalr_target; end
            if (br_taken && 2 > best_rank)   begin best_rank = 2; bc = 3'd1; bt = br_target;   end
            if (stall) begin
                pend_rank = best_rank; pend_code = bc; pend_tgt = bt;
            end else begin
                if (jal_valid && 1 > best_rank) begin best_rank = 1; bc = 3'd2; bt = jal_target; end
                pend_rank = 0;
                if (halt_req && best_rank != 4) begin
                    m_pc = m_pc + 32'd4;
                    m_halted = 1'b1;
                end else begin
                    e.src = (best_rank > 0) ? bc : 3'd0;
                    e.fi  = (best_rank > 0);
                    e.fd  = (best_rank > 1);
                    m_pc  = (best_rank > 0) ? bt : m_pc + 32'd4;
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic clr();
        rst = 0; stall = 0; br_taken = 0; jalr_valid = 0; jal_valid = 0;
        trap_req = 0; halt_req = 0;
        br_target = 0; jalr_target = 0; jal_target = 0;
    endtask

    task automatic step();
        model_push();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented cycle against the scoreboard
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc",       pc,                e.pc);
            chk("pc_src",   {29'd0, pc_src},   {29'd0, e.src});
            chk("flush_if", {31'd0, flush_if}, {31'd0, e.fi});
            chk("flush_id", {31'd0, flush_id}, {31'd0, e.fd});
            chk("halted",   {31'd0, halted},   {31'd0, e.halted});
        end
    end

    // Driver: directed scenarios followed by random traffic
    initial begin
        clr();
        rst = 1;
        @(posedge clk);
        #1;
        step(); step();                         // three reset cycles in total
        clr();
        step(); step();                         // boot hold
        chk("wrap_start", pc2, 32'hFFFF_FFFC);
        step();                                 // pc 0 -> 4
        chk("wrap_next", pc2, 32'h0000_0000);
        step(); step(); step();                 // 4, 8, C -> now at 0x10
        halt_req = 1; step(); clr();            // halt at 0x10 -> 0x14 frozen
        br_taken = 1; br_target = 32'h40; step(); clr();
        step();
        rst = 1; step(); clr();
        step(); step(); step();                 // boot, then first RUN cycle
        br_taken = 1; br_target = 32'h40; jal_valid = 1; jal_target = 32'h80;
        step(); clr();
        step(); step();
        stall = 1; jalr_valid = 1; jalr_target = 32'h200; step(); clr();
        stall = 1; br_taken = 1; br_target = 32'h300; step(); clr();
        stall = 1; step(); clr();
        step(); step();                         // release applies JALR
        jal_valid = 1; jal_target = 32'h500; step(); clr();
        stall = 1; br_taken = 1; br_target = 32'h600; jal_valid = 1; jal_target = 32'h700;
        step(); clr();
        jalr_valid = 1; jalr_target = 32'h800; step(); clr();  // live JALR beats pending branch
        step();
        trap_req = 1; halt_req = 1; step(); clr();
        step(); step();

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            br_taken    = ($urandom_range(0, 4) == 0);
            jalr_valid  = ($urandom_range(0, 5) == 0);
            jal_valid   = ($urandom_range(0, 4) == 0);
            trap_req    = ($urandom_range(0, 11) == 0);
            halt_req    = !stall && ($urandom_range(0, 49) == 0);
            br_target   = $urandom & 32'hFFFF_FFFC;
            jalr_target = $urandom & 32'hFFFF_FFFE;
            jal_target  = $urandom & 32'hFFFF_FFFC;
            step();
        end
        clr();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
